// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared op encodings, default widths and accumulator width helper for mac_pipe
package mac_pkg;

    localparam int DW_DEF = 24;
    localparam int GW_DEF = 8;

    typedef enum logic [2:0] {
        OP_MPY  = 3'b000,
        OP_MAC  = 3'b001,
        OP_MPYN = 3'b010,
        OP_MACN = 3'b011,
        OP_LOAD = 3'b100
    } op_e;

    function automatic int acc_width(input int dw, input int gw);
        return 2 * dw + gw;
    endfunction

endpackage

// File: rtl/mac_round.sv
// rtl/mac_round.sv - combinational convergent (round-half-to-even) rounder at bit DW
module mac_round #(
    parameter int AW = 56,
    parameter int DW = 24
) (
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          ovf
);

    localparam logic [AW-1:0] HALF     = AW'(1) << (DW - 1);
    localparam logic [AW-1:0] LOW_MASK = (AW'(1) << DW) - AW'(1);

    logic          tie;
    logic [AW-1:0] inc;
    logic [AW-1:0] sum;

    always_comb begin
        tie = ((din & LOW_MASK) == HALF);
        // An exact tie only rounds up when the kept part is odd.
        inc  = (tie && !din[DW]) ? '0 : HALF;
        sum  = din + inc;
        dout = sum & ~LOW_MASK;
        ovf  = !din[AW-1] && sum[AW-1];
    end

endmodule

// File: rtl/mac_pipe.sv
// rtl/mac_pipe.sv - 2-stage valid/ready signed-fractional MAC; MAC_PIPE_SAT_EN enables saturation on overflow
module mac_pipe
    import mac_pkg::*;
#(
    parameter  int DW   = DW_DEF,
    parameter  int GW   = GW_DEF,
    parameter  int NACC = 2,
    localparam int AW   = acc_width(DW, GW),
    localparam int AS   = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic [2:0]    op,
    input  logic [AS-1:0] acc_sel,
    input  logic          rnd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] acc_out,
    output logic [AS-1:0] acc_idx,
    output logic          ext,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int PW = 2 * DW;

    logic          s1_valid_q, s1_valid_d;
    logic [AW-1:0] s1_p_q, s1_p_d;
    logic [2:0]    s1_op_q, s1_op_d;
    logic [AS-1:0] s1_sel_q, s1_sel_d;
    logic          s1_rnd_q, s1_rnd_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] acc_out_q, acc_out_d;
    logic [AS-1:0] acc_idx_q, acc_idx_d;
    logic          ext_q, ext_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] acc_q [NACC];
    logic [AW-1:0] acc_d [NACC];

    logic                 advance;
    logic signed [PW-1:0] xs, ys, prod;
    logic signed [AW-1:0] prod_ext, p_mul;
    logic [AW-1:0]        p_new;
    logic [AW-1:0]        acc_rd, addend, sum, sum_s, rnd_val, r;
    logic                 add_ovf, rnd_ovf, use_rnd, ovf_set;
    logic [GW:0]          ext_bits;

    assign advance = !(out_valid_q && !out_ready);
    assign in_ready = advance;

    // Stage 1: exact product, doubled to align the fraction point at bit 2*DW-1.
    always_comb begin
        xs       = PW'($signed(x));
        ys       = PW'($signed(y));
        prod     = xs * ys;
        prod_ext = AW'(prod);
        p_mul    = prod_ext <<< 1;
        case (op)
            OP_MPY, OP_MAC:   p_new = p_mul;
            OP_MPYN, OP_MACN: p_new = -p_mul;
            OP_LOAD:          p_new = AW'($signed({x, y}));
            default:          p_new = '0;
        endcase
    end

    // Stage 2 reads its own accumulator registers, so dependent MACs chain without bubbles.
    always_comb begin
        acc_rd = '0;
        for (int i = 0; i < NACC; i++) begin
            if (AS'(i) == s1_sel_q) acc_rd = acc_q[i];
        end
        addend  = (s1_op_q == OP_MAC || s1_op_q == OP_MACN) ? acc_rd : '0;
        sum     = addend + s1_p_q;
        add_ovf = (addend[AW-1] == s1_p_q[AW-1]) && (sum[AW-1] != addend[AW-1]);
`ifdef MAC_PIPE_SAT_EN
        sum_s = add_ovf ? (addend[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}}) : sum;
`else
        sum_s = sum;
`endif
    end

    mac_round #(
        .AW(AW),
        .DW(DW)
    ) u_round (
        .din (sum_s),
        .dout(rnd_val),
        .ovf (rnd_ovf)
    );

    always_comb begin
        use_rnd = s1_rnd_q && (s1_op_q != OP_LOAD);
        r       = use_rnd ? rnd_val : sum_s;
`ifdef MAC_PIPE_SAT_EN
        if (use_rnd && rnd_ovf) r = {1'b0, {(AW-1){1'b1}}};
`endif
        ovf_set  = add_ovf || (use_rnd && rnd_ovf);
        ext_bits = r[AW-1:PW-1];
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_p_d      = s1_p_q;
        s1_op_d     = s1_op_q;
        s1_sel_d    = s1_sel_q;
        s1_rnd_d    = s1_rnd_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        acc_idx_d   = acc_idx_q;
        ext_d       = ext_q;
        acc_d       = acc_q;
        if (advance) begin
            s1_valid_d  = in_valid && (op <= OP_LOAD);
            s1_p_d      = p_new;
            s1_op_d     = op;
            s1_sel_d    = acc_sel;
            s1_rnd_d    = rnd;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                acc_out_d = r;
                acc_idx_d = s1_sel_q;
                ext_d     = !((&ext_bits) || !(|ext_bits));
                for (int i = 0; i < NACC; i++) begin
                    if (AS'(i) == s1_sel_q) acc_d[i] = r;
                end
            end
        end
        // A same-cycle overflow wins over the clear.
        if (advance && s1_valid_q && ovf_set) ovf_d = 1'b1;
        else if (ovf_clr)                     ovf_d = 1'b0;
        else                                  ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_p_q      <= '0;
            s1_op_q     <= '0;
            s1_sel_q    <= '0;
            s1_rnd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            acc_idx_q   <= '0;
            ext_q       <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_p_q      <= s1_p_d;
            s1_op_q     <= s1_op_d;
            s1_sel_q    <= s1_sel_d;
            s1_rnd_q    <= s1_rnd_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            acc_idx_q   <= acc_idx_d;
            ext_q       <= ext_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < NACC; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign acc_idx   = acc_idx_q;
    assign ext       = ext_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// tb/tb_mac_pipe.sv - scoreboard bench for mac_pipe (default DW=24, GW=8, NACC=2)
module tb_mac_pipe;
    import mac_pkg::*;

    localparam int DW = 24;
    localparam int AW = 56;
    localparam int AS = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x, y;
    logic [2:0]    op;
    logic [AS-1:0] acc_sel;
    logic          rnd;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] acc_out;
    logic [AS-1:0] acc_idx;
    logic          ext;
    logic          ovf;
    logic          ovf_clr;

    mac_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .op       (op),
        .acc_sel  (acc_sel),
        .rnd      (rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc_out  (acc_out),
        .acc_idx  (acc_idx),
        .ext      (ext),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] acc;
        logic [AS-1:0] idx;
        logic          ext;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic exp_ovf  = 1'b0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic ext_of(input logic [AW-1:0] v);
        logic [AW-2*DW:0] top;
        top = v[AW-1:2*DW-1];
        return !((top == '0) || (top == '1));
    endfunction

    task automatic issue(input logic [2:0] o, input logic [DW-1:0] xv, input logic [DW-1:0] yv,
                         input logic [AS-1:0] s, input logic r, input logic push,
                         input logic [AW-1:0] e);
        exp_t ent;
        int   n;
        if (push) begin
            ent.acc = e;
            ent.idx = s;
            ent.ext = ext_of(e);
            ent.ovf = exp_ovf;
            sb.push_back(ent);
        end
        in_valid = 1'b1;
        op       = o;
        x        = xv;
        y        = yv;
        acc_sel  = s;
        rnd      = r;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_timeout", AW'(in_ready), AW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", AW'(sb.size()), AW'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic ovf_run();
        logic [AW-1:0] e;
        e = 56'h00_7FFF_FFFF_FFFF;
        issue(OP_LOAD, 24'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, e);
        for (int k = 1; k <= 256; k++) begin
            e = e + 56'h00_8000_0000_0000;
            if (k == 256) begin
                exp_ovf = 1'b1;
`ifdef MAC_PIPE_SAT_EN
                e = 56'h7F_FFFF_FFFF_FFFF;
`endif
            end
            issue(OP_MAC, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b1, e);
        end
        drain();
`ifdef MAC_PIPE_SAT_EN
        chk("ovf_run_final", acc_out, 56'h7F_FFFF_FFFF_FFFF);
`else
        chk("ovf_run_final", acc_out, 56'h80_7FFF_FFFF_FFFF);
`endif
        chk("ovf_sticky", AW'(ovf), AW'(1));
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output got=%h exp=none", acc_out);
            end else begin
                e = sb.pop_front();
                chk("acc_out", acc_out, e.acc);
                chk("acc_idx", AW'(acc_idx), AW'(e.idx));
                chk("ext", AW'(ext), AW'(e.ext));
                chk("ovf", AW'(ovf), AW'(e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    logic [AW-1:0] burst_exp [4];

    initial begin
        burst_exp[0] = 56'h00_0800_0000_0000;
        burst_exp[1] = 56'h00_1000_0000_0000;
        burst_exp[2] = 56'h00_1800_0000_0000;
        burst_exp[3] = 56'h00_2000_0000_0000;
        reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; op = '0; acc_sel = '0;
        rnd = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", AW'(out_valid), AW'(0));
        chk("rst_acc_out", acc_out, '0);
        chk("rst_acc_idx", AW'(acc_idx), AW'(0));
        chk("rst_ext", AW'(ext), AW'(0));
        chk("rst_ovf", AW'(ovf), AW'(0));
        chk("rst_in_ready", AW'(in_ready), AW'(1));
        @(posedge clk);
        #1;

        issue(OP_MPY, 24'h400000, 24'h400000, 1'b0, 1'b0, 1'b1, 56'h00_2000_0000_0000);
        chk("lat_edge1", AW'(out_valid), AW'(0));
        @(posedge clk);
        #1;
        chk("lat_edge2", AW'(out_valid), AW'(1));
        issue(OP_MPY,  24'h800000, 24'h800000, 1'b0, 1'b0, 1'b1, 56'h00_8000_0000_0000);
        issue(OP_MPYN, 24'h400000, 24'h400000, 1'b0, 1'b0, 1'b1, 56'hFF_E000_0000_0000);
        issue(OP_MPY,  24'h000001, 24'h600000, 1'b0, 1'b1, 1'b1, 56'h00_0000_0100_0000);
        issue(OP_MPY,  24'h000001, 24'h200000, 1'b0, 1'b1, 1'b1, 56'h00_0000_0000_0000);
        issue(3'b101,  24'h123456, 24'h654321, 1'b0, 1'b0, 1'b0, '0);
        issue(OP_LOAD, 24'h000001, 24'h800000, 1'b0, 1'b0, 1'b1, 56'h00_0000_0180_0000);
        issue(OP_MAC,  24'h000000, 24'h000000, 1'b0, 1'b1, 1'b1, 56'h00_0000_0200_0000);
        issue(OP_LOAD, 24'h000002, 24'h800000, 1'b0, 1'b0, 1'b1, 56'h00_0000_0280_0000);
        issue(OP_MAC,  24'h000000, 24'h000000, 1'b0, 1'b1, 1'b1, 56'h00_0000_0200_0000);
        issue(OP_MACN, 24'h400000, 24'h400000, 1'b0, 1'b0, 1'b1, 56'hFF_E000_0200_0000);
        issue(OP_MAC,  24'h400000, 24'h400000, 1'b0, 1'b0, 1'b1, 56'h00_0000_0200_0000);
        drain();

        fork
            begin
                for (int k = 0; k < 4; k++)
                    issue(OP_MAC, 24'h200000, 24'h200000, 1'b1, 1'b0, 1'b1, burst_exp[k]);
            end
            begin
                repeat (2) @(posedge clk);
                #2 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", AW'(in_ready), AW'(0));
                end
                @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        issue(OP_MAC, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1, 56'h00_0000_0200_0000);
        drain();

        ovf_run();
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        chk("ovf_clr", AW'(ovf), AW'(0));

        ovf_run();
        out_ready = 1'b0;
        issue(OP_MPY, 24'h400000, 24'h400000, 1'b0, 1'b0, 1'b0, '0);
        issue(OP_MAC, 24'h800000, 24'h800000, 1'b1, 1'b0, 1'b0, '0);
        chk("pre_rst_valid", AW'(out_valid), AW'(1));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_ovf = 1'b0;
        chk("rst2_out_valid", AW'(out_valid), AW'(0));
        chk("rst2_ovf", AW'(ovf), AW'(0));
        chk("rst2_in_ready", AW'(in_ready), AW'(1));
        chk("rst2_acc_out", acc_out, '0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        issue(OP_MAC, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1, '0);
        issue(OP_MAC, 24'h000000, 24'h000000, 1'b1, 1'b0, 1'b1, '0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
